// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the CPU subsystem.
package cpu_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_LEN,
    LD_DATA,
    LD_CSUM,
    LD_RUN,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in (valid/ready) plus the memory write port driven by the loader.
interface prog_loader_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr, mem_addr, mem_din
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr, mem_addr, mem_din
  );
endinterface

// File: rtl/prog_loader.sv
// Loads a LEN/data/CSUM framed byte stream into CPU memory and releases the
// CPU from reset once a frame with a correct checksum has been stored.
module prog_loader
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_rst,
  output logic         done,
  output logic         err
);

  ld_state_t         state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [CNT_W-1:0]  rem_q, rem_n;
  logic [DATA_W-1:0] acc_q, acc_n;

  logic              ready_q, ready_n;
  logic              wr_q, wr_n;
  logic [ADDR_W-1:0] waddr_q, waddr_n;
  logic [DATA_W-1:0] wdin_q, wdin_n;
  logic              cpu_rst_q, cpu_rst_n;
  logic              done_q, done_n;
  logic              err_q, err_n;

  logic              xfer;

  // ready is registered, so there is no in_valid -> in_ready path
  assign xfer = bus.in_valid && ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LD_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr_q;
    rem_n   = rem_q;
    acc_n   = acc_q;
    wr_n    = 1'b0;
    waddr_n = waddr_q;
    wdin_n  = wdin_q;

    case (state)
      LD_IDLE, LD_RUN, LD_ERR: begin
        if (start) begin
          state_n = LD_LEN;
          addr_n  = '0;
          acc_n   = '0;
        end
      end
      LD_LEN: begin
        if (xfer) begin
          if (bus.in_data == '0 || bus.in_data > DATA_W'(DEPTH)) begin
            state_n = LD_ERR;
          end else begin
            rem_n   = CNT_W'(bus.in_data);
            state_n = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (xfer) begin
          wr_n    = 1'b1;
          waddr_n = addr_q;
          wdin_n  = bus.in_data;
          // wraps to 0 after address 31 on a full-depth frame; never used
          addr_n  = addr_q + ADDR_W'(1);
          acc_n   = acc_q + bus.in_data;
          rem_n   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_n = LD_CSUM;
          end
        end
      end
      LD_CSUM: begin
        if (xfer) begin
          state_n = (bus.in_data == acc_q) ? LD_RUN : LD_ERR;
        end
      end
      default: state_n = LD_IDLE;
    endcase

    // status outputs are registered copies of the upcoming state
    ready_n   = (state_n == LD_LEN) || (state_n == LD_DATA) || (state_n == LD_CSUM);
    cpu_rst_n = (state_n != LD_RUN);
    done_n    = (state_n == LD_RUN);
    err_n     = (state_n == LD_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      waddr_q   <= '0;
      wdin_q    <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      addr_q    <= addr_n;
      rem_q     <= rem_n;
      acc_q     <= acc_n;
      ready_q   <= ready_n;
      wr_q      <= wr_n;
      waddr_q   <= waddr_n;
      wdin_q    <= wdin_n;
      cpu_rst_q <= cpu_rst_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.mem_wr   = wr_q;
  assign bus.mem_addr = waddr_q;
  assign bus.mem_din  = wdin_q;
  assign cpu_rst      = cpu_rst_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule
